// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide unit: owns HI/LO, runs a fixed-length busy window per op
// and commits the precomputed result when the window closes. `MDU_ABORT_EN adds abort.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        abort,
  output logic        start,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  md_res_t     pend_q, pend_d;
  md_res_t     arch_q, arch_d;
  md_res_t     res;
  logic        abort_hit;
  logic        is_mul;

  assign busy      = (state_q == S_RUN);
  assign start     = en && (op != 4'd0) && (op <= OP_DIVU) && !busy;
  assign stall_req = start | busy;
  assign hi        = arch_q.hi;
  assign lo        = arch_q.lo;
  assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);

`ifdef MDU_ABORT_EN
  assign abort_hit = abort & busy;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_hit    = 1'b0;
`endif

  // One multiplier for both flavours: the low 64 bits of a 64x64 product of the
  // sign- or zero-extended operands are the correct 32x32 result either way.
  logic        mul_sgn;
  logic [63:0] mul_a, mul_b, prod;

  assign mul_sgn = (op == OP_MULT);
  assign mul_a   = {{32{mul_sgn & rs_val[31]}}, rs_val};
  assign mul_b   = {{32{mul_sgn & rt_val[31]}}, rt_val};
  assign prod    = mul_a * mul_b;

  // Signed divide done on magnitudes; 0x80000000 / -1 naturally yields
  // quotient 0x80000000 and remainder 0.
  logic        div_sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, div_q, div_r;

  assign div_sgn = (op == OP_DIV);
  assign a_neg   = div_sgn & rs_val[31];
  assign b_neg   = div_sgn & rt_val[31];
  assign a_mag   = a_neg ? (32'd0 - rs_val) : rs_val;
  assign b_mag   = b_neg ? (32'd0 - rt_val) : rt_val;
  assign b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag   = a_mag / b_safe;
  assign r_mag   = a_mag % b_safe;
  assign div_q   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign div_r   = a_neg ? (32'd0 - r_mag) : r_mag;

  // Divide by zero re-commits the current HI/LO, leaving them unchanged.
  always_comb begin
    res = arch_q;
    case (op)
      OP_MULT, OP_MULTU: res = '{hi: prod[63:32], lo: prod[31:0]};
      OP_DIV, OP_DIVU: begin
        if (rt_val != 32'd0) res = '{hi: div_r, lo: div_q};
      end
      default: res = arch_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    arch_d  = arch_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = is_mul ? MULT_LD : DIV_LD;
          pend_d  = res;
        end else if (en && op == OP_MTHI) begin
          arch_d.hi = rs_val;
        end else if (en && op == OP_MTLO) begin
          arch_d.lo = rs_val;
        end
      end
      S_RUN: begin
        if (abort_hit) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
          pend_d  = '0;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
          arch_d  = pend_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= '0;
      arch_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      arch_q  <= arch_d;
    end
  end

  always_comb begin
    md_out = 32'd0;
    if (op == OP_MFHI)      md_out = arch_q.hi;
    else if (op == OP_MFLO) md_out = arch_q.lo;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus random ops checked
// every cycle against an arithmetic reference model of HI/LO and the busy window.
module tb_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MDU_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b0, en = 1'b0, abort = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rs_val = 32'd0, rt_val = 32'd0;
  logic        start, busy, stall_req;
  logic [31:0] md_out, hi, lo;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .abort(abort), .start(start), .busy(busy), .stall_req(stall_req),
    .md_out(md_out), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: architectural HI/LO, pending result, cycles left in window.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  int          m_left = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outs();
    logic mb, ms;
    logic [31:0] mo;
    mb = (m_left > 0);
    ms = en && (op >= 4'd1) && (op <= 4'd4) && !mb;
    mo = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
    chk("start", {31'd0, start}, {31'd0, ms});
    chk("busy", {31'd0, busy}, {31'd0, mb});
    chk("stall_req", {31'd0, stall_req}, {31'd0, ms | mb});
    chk("md_out", md_out, mo);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  task automatic model_edge();
    longint sa, sb, q, r;
    logic [63:0] p;
    if (ABORT_EN && abort && m_left > 0) begin
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (en) begin
      case (op)
        4'd1: begin
          sa = longint'($signed(rs_val)); sb = longint'($signed(rt_val));
          p = sa * sb; p_hi = p[63:32]; p_lo = p[31:0]; m_left = MC;
        end
        4'd2: begin
          p = {32'd0, rs_val} * {32'd0, rt_val};
          p_hi = p[63:32]; p_lo = p[31:0]; m_left = MC;
        end
        4'd3, 4'd4: begin
          if (rt_val == 32'd0) begin
            p_hi = m_hi; p_lo = m_lo;
          end else begin
            if (op == 4'd3) begin
              sa = longint'($signed(rs_val)); sb = longint'($signed(rt_val));
            end else begin
              sa = longint'({32'd0, rs_val}); sb = longint'({32'd0, rt_val});
            end
            q = sa / sb; r = sa % sb;
            p_lo = q[31:0]; p_hi = r[31:0];
          end
          m_left = DC;
        end
        4'd5: m_hi = rs_val;
        4'd6: m_lo = rs_val;
        default: ;
      endcase
    end
  endtask

  // Called at posedge+1: drive, check mid-cycle, advance model, move to next posedge+1.
  task automatic step(input logic e, input logic [3:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic ab);
    en = e; op = o; rs_val = a; rt_val = b; abort = ab;
    #3;
    check_outs();
    model_edge();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    step(1'b1, 4'd5, 32'h1234_5678, 32'd0, 1'b0);
    step(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
    chk("mthi_lo_zero", lo, 32'd0);

    step(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0); idle(MC);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    step(1'b1, 4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0); idle(MC);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    step(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0); idle(DC);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    step(1'b1, 4'd4, 32'd7, 32'd0, 1'b0); idle(DC);
    chk("divz_hi", hi, 32'hFFFF_FFFF);
    chk("divz_lo", lo, 32'hFFFF_FFFD);

    step(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); idle(DC);
    chk("ovf_hi", hi, 32'd0);
    chk("ovf_lo", lo, 32'h8000_0000);

    // Reset in the fourth busy cycle of a divide.
    step(1'b1, 4'd3, 32'd100, 32'd3, 1'b0); idle(3);
    en = 1'b0; op = 4'd0;
    #2 reset = 1'b0;
    #1;
    chk("amid_hi", hi, 32'd0);
    chk("amid_lo", lo, 32'd0);
    chk("amid_busy", {31'd0, busy}, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0; m_left = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    idle(DC + 2);
    chk("no_late_lo", lo, 32'd0);

    // Second MULT while busy is dropped; MULT right after busy falls is taken.
    step(1'b1, 4'd1, 32'd6, 32'd7, 1'b0);
    step(1'b1, 4'd1, 32'd100, 32'd100, 1'b0);
    idle(MC - 1);
    chk("b2b_lo1", lo, 32'd42);
    step(1'b1, 4'd1, 32'd2, 32'd3, 1'b0); idle(MC);
    chk("b2b_lo2", lo, 32'd6);

    step(1'b1, 4'd5, 32'd1, 32'd0, 1'b0);
    step(1'b1, 4'd6, 32'd2, 32'd0, 1'b0);
    step(1'b1, 4'd3, 32'd100, 32'd3, 1'b0);
    idle(2);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    idle(DC);
    chk("abort_hi", hi, 32'd1);
    chk("abort_lo", lo, ABORT_EN ? 32'd2 : 32'd33);

    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)), pick(), pick(),
           ($urandom_range(0, 15) == 0));
    idle(DC + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
